// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate
// AHB-Lite subordinate backed by a word-organised SRAM. It serves as source
// and destination memory for DMA transfers. Each beat is handled on its own.
// The block applies byte-lane writes per HSIZE and inserts WaitStates wait
// cycles in every OKAY data phase. Out-of-range, misaligned or oversized beats
// get a two-cycle ERROR response.
//
// Ports
//   HCLK       bus clock (single domain)
//   HRESET     synchronous, active-high reset
//   HSEL       subordinate select
//   HADDR      byte address
//   HTRANS     IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HWRITE     1 = write
//   HSIZE      0 = byte, 1 = half, 2 = word
//   HBURST     unused; every beat is decoded independently
//   HWDATA     write data (data phase)
//   HREADY     bus-level ready
//   HRDATA     read data, zero outside the final data cycle of a read
//   HREADYOUT  this subordinate's ready
//   HRESP      0 = OKAY, 1 = ERROR
module ahb_sram_subordinate #(
    parameter int                      AddressWidth = 32,
    parameter int                      DataWidth    = 32,
    parameter int                      MemWords     = 1024,
    parameter logic [AddressWidth-1:0] BaseAddr     = '0,
    parameter int                      WaitStates   = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [AddressWidth-1:0] HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DataWidth-1:0]    HWDATA,
    input  logic                    HREADY,
    output logic [DataWidth-1:0]    HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);

    // Elaboration-time parameter checks
    if (DataWidth != 32) begin : g_bad_width
        $error("ahb_sram_subordinate: only DataWidth = 32 is supported");
    end
    if (WaitStates < 0 || WaitStates > 15) begin : g_bad_waits
        $error("ahb_sram_subordinate: WaitStates must be in 0..15");
    end
    if (BaseAddr[1:0] != 2'b00) begin : g_bad_base
        $error("ahb_sram_subordinate: BaseAddr must be 4-byte aligned");
    end

    localparam int IDX_W = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WaitStates);
    // One extra bit so that BaseAddr + 4*MemWords cannot wrap around.
    localparam logic [AddressWidth:0] BASE_EXT  = {1'b0, BaseAddr};
    localparam logic [AddressWidth:0] LIMIT_EXT = BASE_EXT + (AddressWidth+1)'(4 * MemWords);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      count_reg, count_next;
    logic            write_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [3:0]      be_reg;
    logic [3:0]      fwd_mask_reg;
    logic [DataWidth-1:0] fwd_data_reg;
    logic [DataWidth-1:0] rd_word_reg;
    logic [DataWidth-1:0] rd_merged;

    logic [DataWidth-1:0] mem [MemWords];

    // Address-phase decode
    logic [AddressWidth:0]   haddr_ext;
    logic [AddressWidth-1:0] offset;
    logic [IDX_W-1:0]        addr_idx;
    logic [3:0]              lane_en;
    logic                    addr_err;
    logic                    beat_done;
    logic                    accept;
    logic                    commit;

    assign haddr_ext = {1'b0, HADDR};
    assign offset    = HADDR - BaseAddr;
    assign addr_idx  = offset[IDX_W+1:2];
    assign addr_err  = (HSIZE > 3'd2)
                     || (HSIZE == 3'd1 && HADDR[0])
                     || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                     || (haddr_ext < BASE_EXT)
                     || (haddr_ext >= LIMIT_EXT);

    // Only bits that feed nothing are collected here.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0], offset[AddressWidth-1:IDX_W+2], offset[1:0]};

    // beat_done: the current data phase (if any) completes this cycle, so a
    // new address phase may be taken.
    assign beat_done = (state_reg == ST_IDLE) || (state_reg == ST_ERR2)
                     || (state_reg == ST_DATA && count_reg == 4'd0);
    assign accept    = HSEL && HREADY && HTRANS[1] && beat_done;
    // Reset in the final cycle suppresses the write.
    assign commit    = (state_reg == ST_DATA) && (count_reg == 4'd0) && write_reg && !HRESET;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_en[gi] = (HSIZE == 3'd0) ? (HADDR[1:0] == LANE) :
                             (HSIZE == 3'd1) ? (HADDR[1] == LANE[1]) : 1'b1;
        // The RAM read register holds pre-write contents when a read is
        // accepted on the edge that commits a write to the same word. Bytes
        // from that write are substituted here.
        assign rd_merged[gi*8 +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                       : rd_word_reg[gi*8 +: 8];
    end

    // State machine: next state and outputs
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state_reg)
            ST_DATA: begin
                HREADYOUT = (count_reg == 4'd0);
                if (count_reg != 4'd0) begin
                    count_next = count_reg - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
            end
            default: ;
        endcase
        if (beat_done) begin
            if (accept && addr_err) begin
                state_next = ST_ERR1;
                count_next = 4'd0;
            end else if (accept) begin
                state_next = ST_DATA;
                count_next = WAIT_INIT;
            end else begin
                state_next = ST_IDLE;
                count_next = 4'd0;
            end
        end
    end

    assign HRDATA = (state_reg == ST_DATA && count_reg == 4'd0 && !write_reg) ? rd_merged : '0;

    // State registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg    <= ST_IDLE;
            count_reg    <= 4'd0;
            write_reg    <= 1'b0;
            fwd_mask_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                write_reg    <= HWRITE;
                fwd_mask_reg <= (commit && addr_idx == idx_reg) ? be_reg : 4'd0;
            end
        end
    end

    // Captured beat attributes and forwarding data (no reset needed)
    always_ff @(posedge HCLK) begin
        if (accept) begin
            idx_reg      <= addr_idx;
            be_reg       <= lane_en;
            fwd_data_reg <= HWDATA;
        end
    end

    // SRAM: byte-enabled write port, registered read
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_reg[i]) begin
                    mem[idx_reg][i*8 +: 8] <= HWDATA[i*8 +: 8];
                end
            end
        end
        if (accept && !addr_err) begin
            rd_word_reg <= mem[addr_idx];
        end
    end

endmodule
